// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the DLX instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [0:WORD_W-1] word_t;

  localparam word_t PC_INCR  = 32'd4;
  localparam word_t DLX_NOP  = 32'h0000_0000;
  localparam word_t DLX_HALT = 32'h4400_0000;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: register jump, PC-relative branch, stall hold, or sequential.
module fetch_next_pc
  import fetch_stage_pkg::*;
(
  input  word_t pc,
  input  logic  stall,
  input  logic  if_branch,
  input  logic  if_gp_branch,
  input  word_t branch_offset,
  input  word_t branch_base,
  input  word_t gp_target,
  output word_t pc_plus4,
  output word_t next_pc,
  output logic  redirect
);

  assign pc_plus4 = pc + PC_INCR;

  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (if_gp_branch) begin
      next_pc  = gp_target;
      redirect = 1'b1;
    end else if (if_branch) begin
      next_pc  = branch_base + branch_offset;
      redirect = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// DLX instruction fetch: PC register, IF/ID pipeline register, halt detection
// and a count of valid fetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter word_t NOP_INSTR  = DLX_NOP,
  parameter word_t HALT_INSTR = DLX_HALT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [0:31] iaddr,
  input  logic [0:31] inst_from_mem,
  input  logic        stall,
  input  logic        if_branch,
  input  logic        if_gp_branch,
  input  logic [0:31] if_branch_offset,
  input  logic [0:31] if_branch_base,
  input  logic [0:31] if_gp_target,
  output logic [0:31] id_instr,
  output logic [0:31] id_pc_plus4,
  output logic        id_valid,
  output logic        halted,
  output logic [0:31] fetch_count
);

  logic [0:0] state;
  word_t      pc;
  word_t      pc_plus4;
  word_t      next_pc;
  logic       redirect;

  fetch_next_pc u_next_pc (
    .pc            (pc),
    .stall         (stall),
    .if_branch     (if_branch),
    .if_gp_branch  (if_gp_branch),
    .branch_offset (if_branch_offset),
    .branch_base   (if_branch_base),
    .gp_target     (if_gp_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign iaddr  = pc;
  assign halted = (state == ST_HALTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      id_instr    <= NOP_INSTR;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (state == ST_HALTED) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= next_pc;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr    <= inst_from_mem;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
      // PC stays on the halt word so iaddr keeps pointing at it while frozen
      if (inst_from_mem == HALT_INSTR) begin
        state <= ST_HALTED;
      end else begin
        pc <= next_pc;
      end
    end
  end

endmodule
